// File: rtl/if_id_hazard_ctrl_pkg.sv
// Shared definitions for the IF/ID hazard controller: state encodings,
// the NOP instruction word and the default register-specifier width.
package if_id_hazard_ctrl_pkg;

   localparam int DEF_REG_W = 5;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_WAIT  = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/if_id_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Holds at all-ones instead of wrapping so a long run never reads as small.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up on each enabled cycle until every bit is set, then hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID pipeline sequencer: decides every cycle whether the PC and IF/ID
// advance, hold or flush, and whether ID/EX takes a bubble. Handles
// load-use hazards, taken branches from EX and data-memory wait states.
module if_id_hazard_ctrl
   import if_id_hazard_ctrl_pkg::*;
#(
   parameter int REG_W             = DEF_REG_W,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNT_W             = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Extra stall cycles owed after the first hazard cycle
   localparam logic [2:0] LOAD_EXTRA = 3'(LOAD_STALL_CYCLES - 1);

   ctrl_state_t state;
   ctrl_state_t state_nxt;
   logic [2:0]  scnt;
   logic [2:0]  scnt_nxt;
   logic        hz;
   logic        stall_pend;

   assign hz = ex_mem_read && (ex_rd != '0) &&
               ((id_uses_rs && (id_rs == ex_rd)) ||
                (id_uses_rt && (id_rt == ex_rd)));

   assign ctrl_state = state;

   // Zero-latency decision: outputs and next state from state plus inputs,
   // priority mem_busy > branch > pending stall > new hazard
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      state_nxt   = ST_RUN;
      scnt_nxt    = 3'd0;
      stall_pend  = (state == ST_STALL) || ((state == ST_WAIT) && (scnt != 3'd0));
      if (!rst_n) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (mem_busy) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         state_nxt   = ST_WAIT;
         scnt_nxt    = scnt;
      end else if (ex_branch_taken) begin
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (stall_pend) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         if (scnt > 3'd1) begin
            state_nxt = ST_STALL;
            scnt_nxt  = scnt - 3'd1;
         end
      end else if (hz) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         if (LOAD_STALL_CYCLES > 1) begin
            state_nxt = ST_STALL;
            scnt_nxt  = LOAD_EXTRA;
         end
      end
   end

   // State and stall down-counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
         scnt  <= 3'd0;
      end else begin
         state <= state_nxt;
         scnt  <= scnt_nxt;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (~pc_write),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ifid_flush),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Scoreboard bench for if_id_hazard_ctrl: a driver issues directed and
// random cycles and queues the reference model's expected response; a
// monitor on the falling edge pops and compares.
module tb_if_id_hazard_ctrl;

   localparam int REG_W   = 5;
   localparam int LSC     = 3;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic             ex_mem_read;
   logic [REG_W-1:0] ex_rd;
   logic             ex_branch_taken;
   logic             mem_busy;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_bubble;
   logic [1:0]       ctrl_state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   typedef struct {
      logic [3:0]       outs;
      logic [1:0]       st;
      logic [CNT_W-1:0] scnt;
      logic [CNT_W-1:0] fcnt;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   int   m_left  = 0;
   int   m_state = 0;
   int   m_stall = 0;
   int   m_flush = 0;

   if_id_hazard_ctrl #(
      .REG_W             (REG_W),
      .LOAD_STALL_CYCLES (LSC),
      .CNT_W             (CNT_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rs      (id_uses_rs),
      .id_uses_rt      (id_uses_rt),
      .ex_mem_read     (ex_mem_read),
      .ex_rd           (ex_rd),
      .ex_branch_taken (ex_branch_taken),
      .mem_busy        (mem_busy),
      .pc_write        (pc_write),
      .ifid_write      (ifid_write),
      .ifid_flush      (ifid_flush),
      .idex_bubble     (idex_bubble),
      .ctrl_state      (ctrl_state),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // One cycle: drive inputs after the edge, then run the reference model
   // (outputs as {pc_write, ifid_write, ifid_flush, idex_bubble}).
   task automatic applyStimulus(input bit rst, input logic [REG_W-1:0] rs,
                                input logic [REG_W-1:0] rt, input bit urs, input bit urt,
                                input bit mr, input logic [REG_W-1:0] rd,
                                input bit br, input bit mb);
      exp_t e;
      bit   hz;
      @(posedge clk);
      #1;
      rst_n           = !rst;
      id_rs           = rs;
      id_rt           = rt;
      id_uses_rs      = urs;
      id_uses_rt      = urt;
      ex_mem_read     = mr;
      ex_rd           = rd;
      ex_branch_taken = br;
      mem_busy        = mb;
      if (rst) begin
         m_left  = 0;
         m_state = 0;
         m_stall = 0;
         m_flush = 0;
      end
      e.st   = 2'(m_state);
      e.scnt = CNT_W'(m_stall);
      e.fcnt = CNT_W'(m_flush);
      hz = mr && (rd != 0) && ((urs && rs == rd) || (urt && rt == rd));
      if (rst) begin
         e.outs = 4'b0011;
      end else if (mb) begin
         e.outs  = 4'b0000;
         m_state = 2;
      end else if (br) begin
         e.outs  = 4'b1011;
         m_left  = 0;
         m_state = 0;
      end else if (m_left > 0) begin
         e.outs  = 4'b0001;
         m_left  = m_left - 1;
         m_state = (m_left > 0) ? 1 : 0;
      end else if (hz) begin
         e.outs  = 4'b0001;
         m_left  = LSC - 1;
         m_state = (m_left > 0) ? 1 : 0;
      end else begin
         e.outs  = 4'b1100;
         m_state = 0;
      end
      sb_q.push_back(e);
      if (!rst) begin
         if (!e.outs[3] && m_stall < CNT_MAX) m_stall++;
         if (e.outs[1] && m_flush < CNT_MAX) m_flush++;
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic randomCycle();
      bit rst;
      rst = ($urandom_range(0, 39) == 0);
      applyStimulus(rst, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), ($urandom_range(0, 1) == 1),
                    5'($urandom_range(0, 3)), ($urandom_range(0, 6) == 0),
                    ($urandom_range(0, 4) == 0));
   endtask

   // Monitor: every cycle presents an output, compare mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("ctrl_outs", {12'd0, pc_write, ifid_write, ifid_flush, idex_bubble}, {12'd0, e.outs});
            checkOutput("ctrl_state", {14'd0, ctrl_state}, {14'd0, e.st});
            checkOutput("stall_cnt", 16'(stall_cnt), 16'(e.scnt));
            checkOutput("flush_cnt", 16'(flush_cnt), 16'(e.fcnt));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      {id_rs, id_rt, id_uses_rs, id_uses_rt} = '0;
      {ex_mem_read, ex_rd, ex_branch_taken, mem_busy} = '0;

      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idleCycles(2);
      // load-use hit on rs, full stall then resume
      applyStimulus(0, 5, 0, 1, 0, 1, 5, 0, 0);
      idleCycles(4);
      // register 0 never causes a stall
      applyStimulus(0, 0, 0, 1, 1, 1, 0, 0, 0);
      // load-use hit on rt
      applyStimulus(0, 1, 7, 0, 1, 1, 7, 0, 0);
      idleCycles(3);
      // branch wins over a simultaneous hazard
      applyStimulus(0, 5, 0, 1, 0, 1, 5, 1, 0);
      idleCycles(1);
      // hazard, then memory freeze in the second stall cycle
      applyStimulus(0, 9, 0, 1, 0, 1, 9, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idleCycles(4);
      // branch aborts a stall in progress
      applyStimulus(0, 3, 0, 1, 0, 1, 3, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      idleCycles(2);
      // reset in the middle of a stall
      applyStimulus(0, 4, 0, 1, 0, 1, 4, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idleCycles(2);
      // long freeze saturates the stall counter
      for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idleCycles(2);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 600; i++) randomCycle();

      @(posedge clk);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_id_hazard_ctrl.md
Name: if_id_hazard_ctrl

Overview:
- Pipeline sequencer for the IF/ID pipeline register and the PC.
- Detects load-use hazards, taken branches resolved in EX, and data-memory wait states.
- Drives PC write-enable, IF/ID write-enable/flush and an ID/EX bubble request.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- REG_W, 5, register-specifier width.
- LOAD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (range 1..7).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  REG_W  source register 1 of the instruction held in IF/ID.
- id_rt  in  REG_W  source register 2 of the instruction held in IF/ID.
- id_uses_rs  in  1  the ID instruction reads id_rs.
- id_uses_rt  in  1  the ID instruction reads id_rt.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_rd  in  REG_W  destination of the EX instruction.
- ex_branch_taken  in  1  branch or jump resolved taken in EX this cycle.
- mem_busy  in  1  data memory is not ready; the whole pipe must freeze.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP (instruction 0) and PC 0; overrides ifid_write.
- idex_bubble  out  1  ID/EX loads a NOP.
- ctrl_state  out  2  current state, for debug.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0.
- flush_cnt  out  CNT_W  saturating count of cycles with ifid_flush=1.

Behaviour:
- Hazard condition: hz = ex_mem_read & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)).
- States:
  - RUN=0.
  - STALL=1, with a 3-bit down-counter scnt.
  - WAIT=2.
  - Encoding 3 is unused; it returns to RUN on the next edge with RUN outputs.
- Outputs are combinational from the state and the current inputs (zero-latency decision). All state and counters update on the rising edge of clk.
- Per-cycle priority, highest first: mem_busy, ex_branch_taken, STALL in progress, hz.
- mem_busy=1 in any state:
  - Outputs: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0 (hold every stage).
  - Next state is WAIT. If the current state is STALL, scnt is preserved.
- WAIT with mem_busy=0: evaluate the rules below exactly as RUN would. A pending STALL resumes from the preserved scnt.
- ex_branch_taken=1 (mem_busy=0):
  - Outputs: pc_write=1, ifid_flush=1, ifid_write=0, idex_bubble=1.
  - Next state is RUN. Any STALL in progress is aborted, because the dependent instruction is squashed.
- RUN with hz=1:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - If LOAD_STALL_CYCLES>1: next state is STALL with scnt = LOAD_STALL_CYCLES-1.
- STALL:
  - Outputs: same as the hz case, regardless of hz.
  - scnt decrements each cycle. When scnt==1, next state is RUN.
- RUN with no event: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- Counters:
  - stall_cnt increments on every cycle with pc_write=0.
  - flush_cnt increments on every cycle with ifid_flush=1.
  - Both hold at all-ones and never wrap.
- Reset (rst_n=0, asynchronous, at any time including mid-stall):
  - State RUN, scnt=0, stall_cnt=0, flush_cnt=0.
  - Outputs during reset: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, so NOPs enter the pipe.
  - Normal RUN outputs resume on the first cycle after rst_n rises.

Decomposition:
- Shared package: state encodings (ST_RUN, ST_STALL, ST_WAIT), the NOP instruction constant, and REG_W.
- One natural sub-module: sat_counter (parameter W; ports clk, rst_n, inc, count), instantiated twice.

Test Plan:
- Load-use hit: ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> for one cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle with ex_mem_read=0, normal RUN outputs; stall_cnt=1.
- Register 0 filter: ex_rd=0, id_rs=0, ex_mem_read=1 -> no stall, pc_write=1.
- Branch over hazard: hz=1 and ex_branch_taken=1 in the same cycle -> ifid_flush=1, pc_write=1, idex_bubble=1; flush_cnt=1, stall_cnt=0.
- LOAD_STALL_CYCLES=3, hazard, then mem_busy high for 2 cycles in the second stall cycle -> total 5 cycles of pc_write=0 (3 stall plus 2 freeze), idex_bubble=0 during the freeze; stall_cnt=5.
- Reset mid-STALL: rst_n low for one cycle -> ifid_flush=1 and idex_bubble=1 immediately, counters 0; after release, ctrl_state=RUN and pc_write=1.
- Saturation with CNT_W=4: hold mem_busy for 20 cycles -> stall_cnt stops at 15.
